baud_tick_gen: RTL

Parametrised baud-rate tick generator for the UART receiver and transmitter. It divides `clk` by a runtime-programmable divisor to produce an oversampling tick. It then counts those ticks over a parametrised oversampling ratio to produce a mid-bit sample strobe and an end-of-bit strobe. It replaces the fixed divide-by-8 counter and adds a loadable divisor, phase resync and registered strobes.

---
 rtl/baud_tick_gen_if.sv | 25 ++
 rtl/baud_tick_gen.sv | 115 +++++++++++
 2 files changed

// File: rtl/baud_tick_gen_if.sv
// Port bundle for baud_tick_gen: control inputs from the UART core and the
// tick/oversample-index outputs returned to it.
interface baud_tick_gen_if #(
  parameter int DIV_W = 16,
  parameter int OSR_W = 4
);
  logic             en;
  logic             sync;
  logic [DIV_W-1:0] div_val;
  logic             div_load;
  logic             sample_tick;
  logic             mid_tick;
  logic             bit_tick;
  logic [OSR_W-1:0] os_count;

  modport master (
    output en, sync, div_val, div_load,
    input  sample_tick, mid_tick, bit_tick, os_count
  );

  modport slave (
    input  en, sync, div_val, div_load,
    output sample_tick, mid_tick, bit_tick, os_count
  );
endinterface

// File: rtl/baud_tick_gen.sv
// Baud tick generator: programmable prescaler feeding an OSR-step oversample counter.
// Define BAUD_MIDBIT_EN to build the mid-bit strobe; otherwise mid_tick is tied low.
module baud_tick_gen #(
  parameter int               DIV_W       = 16,
  parameter int               OSR         = 16,
  parameter int               OSR_W       = $clog2(OSR),
  parameter logic [DIV_W-1:0] DIV_DEFAULT = 16'd27
) (
  input  logic            clk,
  input  logic            reset,
  baud_tick_gen_if.slave  bus
);

  localparam logic [OSR_W-1:0] OS_LAST = OSR_W'(OSR - 1);

  logic [DIV_W-1:0] pc_q, pc_d;
  logic [DIV_W-1:0] div_active_q, div_active_d;
  logic [DIV_W-1:0] div_pending_q, div_pending_d;
  logic             pend_valid_q, pend_valid_d;
  logic [OSR_W-1:0] os_count_q, os_count_d;
  logic             sample_tick_q, sample_tick_d;
  logic             bit_tick_q, bit_tick_d;
  logic [DIV_W-1:0] div_eff_s;
  logic             term_s;
  logic             bound_s;
  logic             xfer_s;

  always_comb begin
    // A programmed divisor of 0 behaves as divide-by-1.
    div_eff_s = (div_active_q == {DIV_W{1'b0}}) ? DIV_W'(1) : div_active_q;
    term_s    = bus.en & ~bus.sync & (pc_q == (div_eff_s - DIV_W'(1)));
    bound_s   = term_s & (os_count_q == OS_LAST);
    xfer_s    = bound_s | ~bus.en | bus.sync;

    pc_d       = pc_q;
    os_count_d = os_count_q;
    if (bus.sync) begin
      pc_d       = {DIV_W{1'b0}};
      os_count_d = {OSR_W{1'b0}};
    end else if (term_s) begin
      pc_d       = {DIV_W{1'b0}};
      os_count_d = bound_s ? {OSR_W{1'b0}} : (os_count_q + OSR_W'(1));
    end else if (bus.en) begin
      pc_d       = pc_q + DIV_W'(1);
    end else begin
      pc_d       = pc_q;
    end

    // Transfer reads the old pending value before a same-cycle load replaces it.
    div_active_d  = div_active_q;
    div_pending_d = div_pending_q;
    pend_valid_d  = pend_valid_q;
    if (xfer_s && pend_valid_q) begin
      div_active_d = div_pending_q;
      pend_valid_d = 1'b0;
    end else begin
      div_active_d = div_active_q;
    end
    if (bus.div_load) begin
      div_pending_d = bus.div_val;
      pend_valid_d  = 1'b1;
    end else begin
      div_pending_d = div_pending_q;
    end

    sample_tick_d = term_s;
    bit_tick_d    = bound_s;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= {DIV_W{1'b0}};
      os_count_q    <= {OSR_W{1'b0}};
      div_active_q  <= DIV_DEFAULT;
      div_pending_q <= DIV_DEFAULT;
      pend_valid_q  <= 1'b0;
      sample_tick_q <= 1'b0;
      bit_tick_q    <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      os_count_q    <= os_count_d;
      div_active_q  <= div_active_d;
      div_pending_q <= div_pending_d;
      pend_valid_q  <= pend_valid_d;
      sample_tick_q <= sample_tick_d;
      bit_tick_q    <= bit_tick_d;
    end
  end

`ifdef BAUD_MIDBIT_EN
  localparam logic [OSR_W-1:0] OS_MID = OSR_W'(OSR / 2 - 1);
  logic mid_tick_q, mid_tick_d;

  always_comb begin
    mid_tick_d = term_s & (os_count_q == OS_MID);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mid_tick_q <= 1'b0;
    end else begin
      mid_tick_q <= mid_tick_d;
    end
  end

  assign bus.mid_tick = mid_tick_q;
`else
  assign bus.mid_tick = 1'b0;
`endif

  assign bus.sample_tick = sample_tick_q;
  assign bus.bit_tick    = bit_tick_q;
  assign bus.os_count    = os_count_q;

endmodule
